// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4 -- four-way round-robin arbiter for one shared resource
//
// A rotating 2-bit priority pointer picks the first active requester at or
// after the pointer. The winner keeps the grant for as long as it holds its
// request. On release the pointer moves to one past the winner, so every
// requester that keeps its request asserted is served within three other
// grants. There is always at least one idle cycle between two grants.
//
// Optional feature (macro SLICE_LIMIT_EN):
//   When defined, a grant is revoked after SLICE_CYCLES consecutive cycles
//   even if the owner still requests. A one-cycle slice_expired pulse marks
//   the revocation. The SLICE_CYCLES parameter (legal 1..15, default 4)
//   exists only in that build. When undefined, no slice counter is built
//   and slice_expired is tied low.
//
// Ports:
//   clk           in   1  system clock, rising edge
//   rst           in   1  synchronous active-high reset, highest priority
//   req           in   4  request lines, req[i]=1 -> requester i wants access
//   gnt           out  4  registered one-hot grant, zero when idle
//   gnt_id        out  2  index of the granted requester (valid with gnt_valid)
//   gnt_valid     out  1  registered, high while a grant is active
//   ptr           out  2  current round-robin priority pointer
//   slice_expired out  1  one-cycle pulse on a slice-limit revocation
// -----------------------------------------------------------------------------
module rr_arbiter4
`ifdef SLICE_LIMIT_EN
  #(
    parameter int unsigned SLICE_CYCLES = 4
  )
`endif
  (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic [1:0] ptr,
  output logic       slice_expired
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Convert a 2-bit index to a 4-bit one-hot vector.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: returns {found, index}. Offsets are scanned from the
  // farthest to the nearest so the nearest set bit (starting at p) wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [1:0] ptr_q, ptr_d;
  logic       slice_expired_q, slice_expired_d;

  logic [2:0] pick_s;
  logic       win_found_s;
  logic [1:0] win_id_s;
  logic       owner_req_s;
  logic       slice_hit_s;

  // Winner search and owner request lookup.
  always_comb begin
    pick_s      = rr_pick(req, ptr_q);
    win_found_s = pick_s[2];
    win_id_s    = pick_s[1:0];
    owner_req_s = req[gnt_id_q];
  end

`ifdef SLICE_LIMIT_EN
  localparam logic [3:0] SLICE_LAST = 4'(SLICE_CYCLES - 1);

  logic [3:0] slice_cnt_q, slice_cnt_d;

  // Slice counter: zero while idle, so it reads 0 on the first owned cycle.
  always_comb begin
    if (state_q == ST_BUSY) begin
      slice_cnt_d = slice_cnt_q + 4'd1;
    end else begin
      slice_cnt_d = 4'd0;
    end
    slice_hit_s = (state_q == ST_BUSY) && (slice_cnt_q == SLICE_LAST);
  end

  // Slice counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      slice_cnt_q <= 4'd0;
    end else begin
      slice_cnt_q <= slice_cnt_d;
    end
  end
`else
  // No slice limit: the owner keeps the grant while it requests.
  always_comb begin
    slice_hit_s = 1'b0;
  end
`endif

  // Next-state and next-output logic of the grant FSM.
  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    gnt_id_d        = gnt_id_q;
    gnt_valid_d     = gnt_valid_q;
    ptr_d           = ptr_q;
    slice_expired_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d     = ST_BUSY;
          gnt_d       = onehot4(win_id_s);
          gnt_id_d    = win_id_s;
          gnt_valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!owner_req_s) begin
          // Normal release wins over a coincident slice expiry.
          state_d     = ST_IDLE;
          gnt_d       = 4'b0000;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_id_q + 2'd1;
        end else if (slice_hit_s) begin
          state_d         = ST_IDLE;
          gnt_d           = 4'b0000;
          gnt_valid_d     = 1'b0;
          ptr_d           = gnt_id_q + 2'd1;
          slice_expired_d = 1'b1;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_d       = 4'b0000;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs; reset overrides any active grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      gnt_q           <= 4'b0000;
      gnt_id_q        <= 2'd0;
      gnt_valid_q     <= 1'b0;
      ptr_q           <= 2'd0;
      slice_expired_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      gnt_id_q        <= gnt_id_d;
      gnt_valid_q     <= gnt_valid_d;
      ptr_q           <= ptr_d;
      slice_expired_q <= slice_expired_d;
    end
  end

  assign gnt           = gnt_q;
  assign gnt_id        = gnt_id_q;
  assign gnt_valid     = gnt_valid_q;
  assign ptr           = ptr_q;
  assign slice_expired = slice_expired_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter4 -- directed bench for rr_arbiter4 with a behavioural model
// compared every cycle plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic [1:0] ptr;
  logic       slice_expired;

  localparam int SLICE = 4;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  rr_arbiter4 dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .gnt           (gnt),
    .gnt_id        (gnt_id),
    .gnt_valid     (gnt_valid),
    .ptr           (ptr),
    .slice_expired (slice_expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_busy  = 1'b0;
  logic [1:0] m_owner = 2'd0;
  logic [1:0] m_ptr   = 2'd0;
  logic       m_exp   = 1'b0;
  int         m_held  = 0;

  always @(posedge clk) begin : model
    logic       nb;
    logic [1:0] no;
    logic [1:0] np;
    logic       ne;
    int         nh;
    bit         found;
    int         idx;
    nb = m_busy; no = m_owner; np = m_ptr; ne = 1'b0; nh = m_held;
    if (rst) begin
      nb = 1'b0; no = 2'd0; np = 2'd0; nh = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        idx = (int'(m_ptr) + k) % 4;
        if (!found && req[idx]) begin
          found = 1'b1;
          nb = 1'b1;
          no = 2'(idx);
          nh = 1;
        end
      end
    end else if (!req[m_owner]) begin
      nb = 1'b0;
      np = 2'((int'(m_owner) + 1) % 4);
    end
`ifdef SLICE_LIMIT_EN
    else if (m_held == SLICE) begin
      nb = 1'b0;
      np = 2'((int'(m_owner) + 1) % 4);
      ne = 1'b1;
    end
`endif
    else begin
      nh = m_held + 1;
    end
    m_busy  <= nb;
    m_owner <= no;
    m_ptr   <= np;
    m_exp   <= ne;
    m_held  <= nh;
  end

  // Compare DUT against the model on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_gnt", 32'(gnt), m_busy ? 32'(4'b0001 << m_owner) : 32'd0);
      chk("model_gnt_valid", 32'(gnt_valid), 32'(m_busy));
      chk("model_ptr", 32'(ptr), 32'(m_ptr));
      chk("model_slice_expired", 32'(slice_expired), 32'(m_exp));
      if (m_busy) begin
        chk("model_gnt_id", 32'(gnt_id), 32'(m_owner));
      end
    end
  end

  task automatic step(input logic [3:0] r, input logic rr);
    @(negedge clk);
    req = r;
    rst = rr;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] tbl [16] = '{4'b0110, 4'b0110, 4'b0100, 4'b0000, 4'b1111, 4'b1111,
                           4'b1110, 4'b1100, 4'b0000, 4'b0011, 4'b0001, 4'b1000,
                           4'b1000, 4'b0101, 4'b0100, 4'b0010};

  initial begin
    // Reset held with all requests active.
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    cmp_en = 1'b1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(gnt_valid), 32'h0);
    chk("rst_ptr", 32'(ptr), 32'h0);
    chk("rst_slice_expired", 32'(slice_expired), 32'h0);
    step(4'b1111, 1'b0);
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("first_gnt_id", 32'(gnt_id), 32'h0);

    // Order 1, 3, 1 with 3-cycle holds.
    step(4'b1010, 1'b1);
    step(4'b1010, 1'b0);
    chk("ord_gnt1", 32'(gnt), 32'h2);
    step(4'b1010, 1'b0);
    step(4'b1010, 1'b0);
    step(4'b1000, 1'b0);
    chk("ord_idle1", 32'(gnt), 32'h0);
    chk("ord_ptr2", 32'(ptr), 32'h2);
    step(4'b1010, 1'b0);
    chk("ord_gnt3", 32'(gnt), 32'h8);
    chk("ord_id3", 32'(gnt_id), 32'h3);
    step(4'b1010, 1'b0);
    step(4'b1010, 1'b0);
    step(4'b0010, 1'b0);
    chk("ord_idle2", 32'(gnt), 32'h0);
    chk("ord_ptr0", 32'(ptr), 32'h0);
    step(4'b1010, 1'b0);
    chk("ord_gnt1b", 32'(gnt), 32'h2);
    step(4'b1010, 1'b0);
    step(4'b1010, 1'b0);
    step(4'b1000, 1'b0);
    chk("ord_ptr2b", 32'(ptr), 32'h2);

    // Pointer wrap from 3 to 0.
    step(4'b1001, 1'b0);
    chk("wrap_gnt3", 32'(gnt), 32'h8);
    step(4'b1001, 1'b0);
    step(4'b0001, 1'b0);
    chk("wrap_ptr0", 32'(ptr), 32'h0);
    step(4'b1001, 1'b0);
    chk("wrap_gnt0", 32'(gnt), 32'h1);
    chk("wrap_id0", 32'(gnt_id), 32'h0);

    // Reset in the middle of a grant.
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b0);
    chk("mid_gnt2", 32'(gnt), 32'h4);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_valid", 32'(gnt_valid), 32'h0);
    chk("mid_rst_ptr", 32'(ptr), 32'h0);
    step(4'b0100, 1'b0);
    chk("mid_regrant", 32'(gnt), 32'h4);

`ifdef SLICE_LIMIT_EN
    // Slice limit alternation between requesters 0 and 1.
    step(4'b0011, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step(4'b0011, 1'b0);
      chk("slice_gnt0", 32'(gnt), 32'h1);
    end
    step(4'b0011, 1'b0);
    chk("slice_revoke0", 32'(gnt), 32'h0);
    chk("slice_pulse0", 32'(slice_expired), 32'h1);
    for (int c = 0; c < 4; c++) begin
      step(4'b0011, 1'b0);
      chk("slice_gnt1", 32'(gnt), 32'h2);
      chk("slice_nopulse", 32'(slice_expired), 32'h0);
    end
    step(4'b0011, 1'b0);
    chk("slice_pulse1", 32'(slice_expired), 32'h1);
    step(4'b0011, 1'b0);
    chk("slice_gnt0b", 32'(gnt), 32'h1);
`else
    // Long hold without slice limit.
    step(4'b0001, 1'b1);
    for (int c = 0; c < 20; c++) begin
      step(4'b0001, 1'b0);
      chk("hold_gnt", 32'(gnt), 32'h1);
      chk("hold_slice_expired", 32'(slice_expired), 32'h0);
    end
`endif

    // Directed request table, checked by the model each cycle.
    step(4'b0000, 1'b1);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) begin
        step(tbl[i], 1'b0);
      end
    end
    step(4'b0000, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
